// File: rtl/mem_responder.sv
// mem_responder: 64-bit word store behind a request/response handshake, RISC-V load/store sizing.
// Define MEM_RESPONDER_STALL_EN to insert WAIT_CYCLES stall cycles between ACCESS and RESP.
module mem_responder #(
  parameter int unsigned DEPTH       = 512,
  parameter logic [63:0] BASE_ADDR   = 64'h80000000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'd8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
`ifdef MEM_RESPONDER_STALL_EN
  localparam logic [1:0] WAIT   = 2'd3;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
`endif

  if (DEPTH == 0 || WAIT_CYCLES > 65535) begin : gBadParams
    $error("mem_responder: DEPTH must be nonzero and WAIT_CYCLES below 65536");
  end

  logic [1:0]  state;
  logic        curWe;
  logic [63:0] curAddr;
  logic [2:0]  curFunct3;
  logic [63:0] curWdata;
`ifdef MEM_RESPONDER_STALL_EN
  logic [CNT_W-1:0] waitCnt;
`endif

  logic [63:0] mem [DEPTH];

  logic [63:0]      offset;
  logic [2:0]       lane;
  logic [IDX_W-1:0] wordIdx;
  logic             outOfRange;
  logic             misaligned;
  logic             illegal;
  logic             accErr;
  logic [63:0]      memWord;
  logic [63:0]      laneData;
  logic [63:0]      loadData;
  logic [7:0]       sizeMask;
  logic [7:0]       wrMask;
  logic [63:0]      wrData;
  logic             writeEn;

  assign req_ready = (state == IDLE);

  // Decode of the captured request; everything here is valid while in ACCESS.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    misaligned = 1'b0;
    sizeMask   = 8'h01;
    loadData   = '0;

    offset     = curAddr - BASE_ADDR;
    lane       = offset[2:0];
    wordIdx    = offset[IDX_W+2:3];
    outOfRange = (offset >= MEM_BYTES);
    illegal    = curWe ? curFunct3[2] : (curFunct3 == 3'b111);

    case (curFunct3[1:0])
      2'd0: begin misaligned = 1'b0;            sizeMask = 8'h01; end
      2'd1: begin misaligned = curAddr[0];      sizeMask = 8'h03; end
      2'd2: begin misaligned = |curAddr[1:0];   sizeMask = 8'h0F; end
      default: begin misaligned = |curAddr[2:0]; sizeMask = 8'hFF; end
    endcase

    accErr = outOfRange | misaligned | illegal;

    // Out-of-range indices may not exist in the array, so park the read on word 0.
    memWord  = mem[outOfRange ? '0 : wordIdx];
    laneData = memWord >> {lane, 3'b000};

    case (curFunct3)
      3'b000:  loadData = {{56{laneData[7]}},  laneData[7:0]};
      3'b001:  loadData = {{48{laneData[15]}}, laneData[15:0]};
      3'b010:  loadData = {{32{laneData[31]}}, laneData[31:0]};
      3'b100:  loadData = {56'd0, laneData[7:0]};
      3'b101:  loadData = {48'd0, laneData[15:0]};
      3'b110:  loadData = {32'd0, laneData[31:0]};
      default: loadData = laneData;
    endcase

    wrMask  = sizeMask << lane;
    wrData  = curWdata << {lane, 3'b000};
    writeEn = (state == ACCESS) && curWe && !accErr;
  end

  // NOTE: storage has no reset; contents survive reset and change only on a successful store.
  always_ff @(posedge clk) begin
    if (writeEn) begin
      for (int b = 0; b < 8; b++) begin
        if (wrMask[b]) mem[wordIdx][b*8 +: 8] <= wrData[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      curWe     <= 1'b0;
      curAddr   <= '0;
      curFunct3 <= '0;
      curWdata  <= '0;
`ifdef MEM_RESPONDER_STALL_EN
      waitCnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            curWe     <= req_we;
            curAddr   <= req_addr;
            curFunct3 <= req_funct3;
            curWdata  <= req_wdata;
            state     <= ACCESS;
          end
        end

        ACCESS: begin
          rsp_err   <= accErr;
          rsp_rdata <= (accErr || curWe) ? '0 : loadData;
`ifdef MEM_RESPONDER_STALL_EN
          if (WAIT_CYCLES == 0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            state   <= WAIT;
            waitCnt <= CNT_W'(WAIT_CYCLES);
          end
`else
          state     <= RESP;
          rsp_valid <= 1'b1;
`endif
        end

`ifdef MEM_RESPONDER_STALL_EN
        WAIT: begin
          if (waitCnt == CNT_W'(1)) begin
            waitCnt   <= '0;
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
`endif

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: byte-addressed reference model, randomized traffic,
// directed load/store/error/backpressure/reset sequences and response latency checks.
module tb_mem_responder;

  localparam int unsigned DEPTH = 512;
  localparam logic [63:0] BASE  = 64'h80000000;
  localparam int unsigned WAITC = 3;
`ifdef MEM_RESPONDER_STALL_EN
  localparam int EXP_LAT = 2 + WAITC;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [63:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  mem_responder #(
    .DEPTH(DEPTH),
    .BASE_ADDR(BASE),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_funct3(req_funct3),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          acceptCycle;
  } exp_t;

  exp_t sbQ[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  bit   randBp = 1'b0;

  byte unsigned mbytes [DEPTH*8];

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    #1;
    if (randBp) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: the memory is a flat byte array; a load gathers bytes little-endian and extends.
  function automatic void model_access(input logic we, input logic [63:0] addr,
                                       input logic [2:0] f3, input logic [63:0] wdata,
                                       output logic [63:0] rdata, output logic err);
    int          size;
    logic [63:0] off;
    logic [63:0] val;
    size  = 1 << f3[1:0];
    off   = addr - BASE;
    err   = (off >= 64'(DEPTH*8)) || ((addr % 64'(size)) != 0) ||
            (we ? f3[2] : (f3 == 3'b111));
    rdata = '0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) mbytes[int'(off) + i] = wdata[8*i +: 8];
    end else begin
      val = '0;
      for (int i = 0; i < size; i++) val |= 64'(mbytes[int'(off) + i]) << (8*i);
      if (!f3[2] && size < 8 && val[8*size-1]) val |= ~((64'd1 << (8*size)) - 64'd1);
      rdata = val;
    end
  endfunction

  task automatic handshake(input logic we, input logic [63:0] addr, input logic [2:0] f3,
                           input logic [63:0] wdata, output bit ok);
    int b;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wdata;
    b = 0;
    while (!req_ready && b < 64) begin
      @(negedge clk);
      b++;
    end
    if (!req_ready) begin
      check("req_ready timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic issue(input logic we, input logic [63:0] addr, input logic [2:0] f3,
                       input logic [63:0] wdata, input bit useExp = 1'b0,
                       input logic [63:0] expData = '0, input logic expErr = 1'b0);
    exp_t e;
    bit   ok;
    handshake(we, addr, f3, wdata, ok);
    if (!ok) return;
    model_access(we, addr, f3, wdata, e.rdata, e.err);
    if (useExp) begin
      e.rdata = expData;
      e.err   = expErr;
    end
    e.acceptCycle = cycle;
    sbQ.push_back(e);
  endtask

  task automatic wait_rsp(input string name);
    int b;
    b = 0;
    while (!rsp_valid && b < 40) begin
      @(negedge clk);
      b++;
    end
    if (!rsp_valid) check(name, 64'(rsp_valid), 64'd1);
  endtask

  task automatic drain();
    int b;
    b = 0;
    @(negedge clk);
    while (!(sbQ.size() == 0 && !rsp_valid && req_ready) && b < 60) begin
      @(negedge clk);
      b++;
    end
    if (sbQ.size() != 0 || rsp_valid) check("drain timeout", 64'(sbQ.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per response, then checks it stays stable until consumed.
  bit          inResp = 1'b0;
  bit          expectIdle = 1'b0;
  logic [63:0] heldData;
  logic        heldErr;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      inResp     = 1'b0;
      expectIdle = 1'b0;
    end else begin
      if (expectIdle) begin
        check("req_ready after consume", 64'(req_ready), 64'd1);
        check("rsp_valid after consume", 64'(rsp_valid), 64'd0);
        expectIdle = 1'b0;
      end
      if (rsp_valid) begin
        if (!inResp) begin
          if (sbQ.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected response: rdata %h err %0d with empty scoreboard",
                     rsp_rdata, rsp_err);
          end else begin
            e = sbQ.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", 64'(rsp_err), 64'(e.err));
            check("latency", 64'(cycle + 1 - e.acceptCycle), 64'(EXP_LAT));
          end
          heldData = rsp_rdata;
          heldErr  = rsp_err;
          inResp   = 1'b1;
        end else begin
          check("held rsp_rdata", rsp_rdata, heldData);
          check("held rsp_err", 64'(rsp_err), 64'(heldErr));
        end
        check("req_ready in RESP", 64'(req_ready), 64'd0);
        if (rsp_ready) begin
          inResp     = 1'b0;
          expectIdle = 1'b1;
        end
      end else if (inResp) begin
        check("rsp_valid dropped early", 64'(rsp_valid), 64'd1);
        inResp = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          r;
    logic [63:0] a;
    logic [2:0]  f3;

    repeat (3) @(negedge clk);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_rdata", rsp_rdata, 64'd0);
    check("reset rsp_err", 64'(rsp_err), 64'd0);
    #2 reset = 1'b1;
    @(negedge clk);
    check("req_ready after reset", 64'(req_ready), 64'd1);

    for (int w = 0; w < int'(DEPTH); w++) issue(1'b1, BASE + 64'(w) * 8, 3'b011, {$urandom, $urandom});

    issue(1'b1, BASE, 3'b011, 64'h1122334455667788, 1'b1, 64'd0, 1'b0);
    issue(1'b0, BASE, 3'b011, 64'd0, 1'b1, 64'h1122334455667788, 1'b0);
    issue(1'b0, BASE + 7, 3'b000, 64'd0, 1'b1, 64'h0000000000000011, 1'b0);
    issue(1'b1, BASE + 1, 3'b000, 64'h00000000000000F0, 1'b1, 64'd0, 1'b0);
    issue(1'b0, BASE + 1, 3'b100, 64'd0, 1'b1, 64'h00000000000000F0, 1'b0);
    issue(1'b0, BASE + 1, 3'b000, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFFF0, 1'b0);
    issue(1'b0, BASE, 3'b011, 64'd0, 1'b1, 64'h112233445566F088, 1'b0);
    issue(1'b0, BASE + 2, 3'b010, 64'd0, 1'b1, 64'd0, 1'b1);
    issue(1'b1, BASE + 64'h1000, 3'b010, 64'hA5A5A5A5A5A5A5A5, 1'b1, 64'd0, 1'b1);
    issue(1'b0, BASE, 3'b011, 64'd0, 1'b1, 64'h112233445566F088, 1'b0);
    issue(1'b0, BASE, 3'b111, 64'd0, 1'b1, 64'd0, 1'b1);
    issue(1'b1, BASE, 3'b100, 64'hFFFF, 1'b1, 64'd0, 1'b1);
    issue(1'b0, BASE - 8, 3'b011, 64'd0, 1'b1, 64'd0, 1'b1);
    issue(1'b0, BASE + 64'(DEPTH*8) - 8, 3'b011, 64'd0);
    issue(1'b0, BASE + 64'(DEPTH*8), 3'b000, 64'd0, 1'b1, 64'd0, 1'b1);

    // Backpressure: response must hold for several cycles with the request side closed.
    drain();
    rsp_ready = 1'b0;
    issue(1'b0, BASE, 3'b011, 64'd0, 1'b1, 64'h112233445566F088, 1'b0);
    wait_rsp("bp rsp_valid timeout");
    repeat (5) @(posedge clk);
    #1 rsp_ready = 1'b1;
    drain();

    // Reset during ACCESS of a store: the store never lands.
    handshake(1'b1, BASE + 8, 3'b011, 64'hDEADBEEFDEADBEEF, ok);
    #2 reset = 1'b0;
    #1;
    check("mid-access reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid-access reset req_ready", 64'(req_ready), 64'd1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("req_ready after mid-access reset", 64'(req_ready), 64'd1);
    issue(1'b0, BASE + 8, 3'b011, 64'd0);

    // Reset during RESP of a store: the store already landed.
    drain();
    rsp_ready = 1'b0;
    issue(1'b1, BASE + 16, 3'b011, 64'hCAFEF00D12345678, 1'b1, 64'd0, 1'b0);
    wait_rsp("resp-reset rsp_valid timeout");
    #2 reset = 1'b0;
    #1;
    check("resp reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("resp reset rsp_rdata", rsp_rdata, 64'd0);
    check("resp reset rsp_err", 64'(rsp_err), 64'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(1'b0, BASE + 16, 3'b011, 64'd0, 1'b1, 64'hCAFEF00D12345678, 1'b0);

    randBp = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      if (r == 0) a = BASE + 64'(DEPTH*8) + 64'($urandom_range(0, 4095));
      else if (r == 1) a = BASE - 64'($urandom_range(1, 64));
      else begin
        a = BASE + 64'($urandom_range(0, DEPTH - 1)) * 8;
        if (r < 5) a += 64'($urandom_range(0, 7));
        else a += 64'($urandom_range(0, (8 >> f3[1:0]) - 1)) << f3[1:0];
      end
      issue($urandom_range(0, 1) == 1, a, f3, {$urandom, $urandom});
    end
    randBp = 1'b0;
    @(posedge clk);
    #2 rsp_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning the number of 64-bit storage words (4 KiB).
REQ-002 SHALL have parameter BASE_ADDR, default 64'h80000000, meaning the byte address of word 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of stall cycles inserted per access when MEM_RESPONDER_STALL_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, 64 bits: byte address.
REQ-010 SHALL have port req_funct3, input, 3 bits: RISC-V load/store funct3 (size and sign).
REQ-011 SHALL have port req_wdata, input, 64 bits: store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-013 SHALL have port rsp_ready, input, 1 bit: the initiator consumes the response.
REQ-014 SHALL have port rsp_rdata, output, 64 bits: load result, already extended.
REQ-015 SHALL have port rsp_err, output, 1 bit: the access was rejected (misaligned, out of range, or illegal funct3).

Function
REQ-016 SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE, with a WAIT state between ACCESS and RESP only when stalls are enabled.
REQ-017 SHALL drive req_ready=1 only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both 1, and all req_* fields are captured into registers.
REQ-018 SHALL compute offset = addr - BASE_ADDR, word index = offset[63:3], and byte lane = offset[2:0].
REQ-019 SHALL flag an error when offset >= DEPTH*8, or when the access is misaligned: halfword needs addr[0]=0, word needs addr[1:0]=0, doubleword needs addr[2:0]=0.
REQ-020 SHALL treat load funct3 111 and store funct3 1xx as illegal, which sets rsp_err.
REQ-021 SHALL, for loads in ACCESS, select the lane and extend it: lb/lh/lw sign-extend; lbu/lhu/lwu zero-extend; ld is passed through unchanged.
REQ-022 SHALL, for stores in ACCESS, write only the addressed bytes (sb 1, sh 2, sw 4, sd 8) and leave the other bytes of the word unchanged.
REQ-023 SHALL suppress the write on any error, and return rsp_rdata=0 on errors and on all stores.
REQ-024 SHALL hold rsp_valid=1 in RESP with rsp_rdata/rsp_err stable until rsp_ready=1, then return to IDLE on that edge.
REQ-025 SHALL have a minimum latency from the acceptance edge to rsp_valid of 2 cycles without stalls, and 2+WAIT_CYCLES cycles with stalls.
REQ-026 SHALL keep rsp_valid low outside RESP; back-to-back requests therefore have a throughput of at most one per 3 cycles.
REQ-027 SHALL ignore req_valid outside IDLE; the initiator must hold its request until req_ready.

Reset
REQ-028 SHALL, while reset=0 and asynchronously, force state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, and the wait counter to 0.
REQ-029 SHALL abandon an in-flight access when reset asserts mid-operation: a store not yet written is dropped, and a store written in ACCESS remains.
REQ-030 SHALL not reset storage contents.
REQ-031 SHALL drive req_ready=1 on the first clk edge after reset deasserts.

Configuration
REQ-032 SHALL, with MEM_RESPONDER_STALL_EN defined, enter WAIT after ACCESS for WAIT_CYCLES cycles counted by a down-counter; WAIT_CYCLES=0 goes directly to RESP.
REQ-033 SHALL, without MEM_RESPONDER_STALL_EN, contain no WAIT state and no counter logic.

Verification
REQ-034 SHALL cover: sd 64'h1122334455667788 @80000000, then ld @80000000 -> rsp_rdata=64'h1122334455667788, rsp_err=0.
REQ-035 SHALL cover: after REQ-034, lb @80000007 -> 64'h0000000000000011; sb 8'hF0 @80000001 then lbu @80000001 -> 64'hF0 and lb -> 64'hFFFFFFFFFFFFFFF0; ld -> 64'h112233445566F088.
REQ-036 SHALL cover: lw @80000002 (misaligned) -> rsp_err=1, rdata=0; sw @80001000 with DEPTH=512 (out of range) -> rsp_err=1, and a following ld of the same word index returns its prior data.
REQ-037 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata, and rsp_err stable; req_ready=0 throughout; with rsp_ready=1 -> IDLE next cycle.
REQ-038 SHALL cover: reset asserted during ACCESS of sd -> rsp_valid=0 immediately; after release the initiator re-issues the ld.
REQ-039 SHALL cover: with MEM_RESPONDER_STALL_EN and WAIT_CYCLES=3 -> rsp_valid rises exactly 5 cycles after acceptance; without the macro, 2 cycles.
